// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared states, default polynomials and sizing helper for the BIST engine
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        APPLY,
        DRAIN,
        DONE
    } bist_state_t;

    localparam logic [3:0] DEF_LFSR_POLY = 4'b1100;
    localparam logic [7:0] DEF_MISR_POLY = 8'b1011_1000;

    // Counter must be able to hold PATTERNS itself after the final increment.
    function automatic int cnt_width(input int patterns);
        return $clog2(patterns + 1);
    endfunction

endpackage

// File: rtl/bist_shift_reg.sv
// rtl/bist_shift_reg.sv - left-shifting feedback register usable as LFSR or MISR
module bist_shift_reg #(
    parameter int          W         = 4,
    parameter logic [W-1:0] POLY     = '0,
    parameter bit          MODE_MISR = 1'b0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    input  logic [W-1:0] xor_in,
    output logic [W-1:0] value
);

    logic [W-1:0] shifted;
    logic [W-1:0] value_next;

    always_comb begin
        shifted = {value[W-2:0], ^(value & POLY)};
        if (MODE_MISR) begin
            shifted = shifted ^ xor_in;
        end
        value_next = value;
        if (load) begin
            value_next = load_value;
        end else if (enable) begin
            value_next = shifted;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            value <= '0;
        end else begin
            value <= value_next;
        end
    end

endmodule

// File: rtl/bist_engine.sv
// rtl/bist_engine.sv - LFSR-driven self-test of a registered UUT with MISR signature check
module bist_engine
    import bist_pkg::*;
#(
    parameter int               IN_W      = 4,
    parameter int               OUT_W     = 4,
    parameter int               SIG_W     = 8,
    parameter int               PATTERNS  = 16,
    parameter int               UUT_LAT   = 1,
    parameter logic [IN_W-1:0]  LFSR_POLY = DEF_LFSR_POLY,
    parameter logic [SIG_W-1:0] MISR_POLY = DEF_MISR_POLY,
    parameter logic [SIG_W-1:0] GOLDEN    = 8'h27
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bist_start,
    input  logic             bist_abort,
    input  logic [IN_W-1:0]  lfsr_seed,
    input  logic [IN_W-1:0]  func_in,
    input  logic [OUT_W-1:0] uut_resp,
    output logic [IN_W-1:0]  uut_in,
    output logic             uut_rst,
    output logic             bist_running,
    output logic             bist_end,
    output logic             pass_fail,
    output logic [SIG_W-1:0] signature_out
);

    localparam int CW = cnt_width(PATTERNS);
    localparam int VW = (UUT_LAT > 0) ? UUT_LAT : 1;

    bist_state_t      state, state_next;
    logic [CW-1:0]    count;
    logic [2:0]       drain_count;
    logic [VW-1:0]    valid_pipe;
    logic             armed;
    logic             valid_out;
    logic             lfsr_en;
    logic             misr_en;
    logic             sig_match;
    logic             pass_hold;
    logic [IN_W-1:0]  seed_fixed;
    logic [IN_W-1:0]  lfsr_value;
    logic [SIG_W-1:0] misr_value;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bist_start && armed) state_next = INIT;
            INIT:    state_next = APPLY;
            APPLY:   if (count == CW'(PATTERNS - 1)) state_next = (UUT_LAT == 0) ? DONE : DRAIN;
            DRAIN:   if (drain_count == 3'(UUT_LAT - 1)) state_next = DONE;
            DONE:    if (!bist_start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bist_abort) begin
            state_next = IDLE;
        end
    end

    assign bist_running = (state == INIT) || (state == APPLY) || (state == DRAIN);
    assign bist_end     = (state == DONE);
    assign uut_rst      = reset || (state == INIT);
    assign uut_in       = bist_running ? lfsr_value : func_in;

    // A run only starts on a fresh rising request, never on a level left high from before.
    always_ff @(posedge clock) begin
        if (reset) begin
            count       <= '0;
            drain_count <= '0;
            valid_pipe  <= '0;
            pass_hold   <= 1'b0;
            armed       <= 1'b1;
        end else begin
            if (!bist_start) begin
                armed <= 1'b1;
            end else if (state == IDLE && state_next == INIT) begin
                armed <= 1'b0;
            end
            if (state == INIT) begin
                count       <= '0;
                drain_count <= '0;
                valid_pipe  <= '0;
                pass_hold   <= 1'b0;
            end else if (state == APPLY) begin
                count      <= count + 1'b1;
                valid_pipe <= (valid_pipe << 1) | VW'(1);
            end else if (state == DRAIN) begin
                drain_count <= drain_count + 1'b1;
                valid_pipe  <= valid_pipe << 1;
            end else if (state == DONE) begin
                pass_hold <= sig_match;
            end
        end
    end

    assign valid_out  = (UUT_LAT == 0) ? (state == APPLY) : valid_pipe[VW-1];
    assign lfsr_en    = (state == APPLY) && !bist_abort;
    assign misr_en    = ((state == APPLY) || (state == DRAIN)) && valid_out && !bist_abort;
    assign seed_fixed = (lfsr_seed == '0) ? IN_W'(1) : lfsr_seed;

    bist_shift_reg #(
        .W        (IN_W),
        .POLY     (LFSR_POLY),
        .MODE_MISR(1'b0)
    ) u_lfsr (
        .clock     (clock),
        .reset     (reset),
        .load      (state == INIT),
        .load_value(seed_fixed),
        .enable    (lfsr_en),
        .xor_in    ('0),
        .value     (lfsr_value)
    );

    bist_shift_reg #(
        .W        (SIG_W),
        .POLY     (MISR_POLY),
        .MODE_MISR(1'b1)
    ) u_misr (
        .clock     (clock),
        .reset     (reset),
        .load      (state == INIT),
        .load_value('0),
        .enable    (misr_en),
        .xor_in    (SIG_W'(uut_resp)),
        .value     (misr_value)
    );

    // The signature is frozen once DONE is reached, so comparing it there equals the entry value.
    assign sig_match     = (misr_value == GOLDEN);
    assign pass_fail     = (state == DONE) ? sig_match : pass_hold;
    assign signature_out = misr_value;

endmodule

// File: tb/tb_bist_engine.sv
// tb/tb_bist_engine.sv - randomized self-checking bench for bist_engine at latencies 0, 1 and 3
module tb_bist_engine;

    localparam int         P    = 16;
    localparam logic [7:0] GOLD = 8'h01;

    logic       clock = 1'b0;
    logic       reset, bist_start, bist_abort;
    logic [3:0] lfsr_seed, func_in;
    logic [3:0] xor_mask;
    bit         stuck2;

    logic [3:0] in0, in1, in3, resp0, resp1, resp3, d1;
    logic [3:0] d3 [3];
    logic       rst0, rst1, rst3, run0, run1, run3, end0, end1, end3, pf0, pf1, pf3;
    logic [7:0] sig0, sig1, sig3;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    assign resp0 = in0 ^ xor_mask;
    always @(posedge clock) d1 <= in1 ^ xor_mask;
    assign resp1 = stuck2 ? (d1 & 4'b1011) : d1;
    always @(posedge clock) begin
        d3[0] <= in3 ^ xor_mask;
        d3[1] <= d3[0];
        d3[2] <= d3[1];
    end
    assign resp3 = d3[2];

    bist_engine #(.UUT_LAT(0), .GOLDEN(GOLD)) u_lat0 (
        .clock(clock), .reset(reset), .bist_start(bist_start), .bist_abort(bist_abort),
        .lfsr_seed(lfsr_seed), .func_in(func_in), .uut_resp(resp0), .uut_in(in0),
        .uut_rst(rst0), .bist_running(run0), .bist_end(end0), .pass_fail(pf0), .signature_out(sig0));

    bist_engine #(.UUT_LAT(1), .GOLDEN(GOLD)) u_lat1 (
        .clock(clock), .reset(reset), .bist_start(bist_start), .bist_abort(bist_abort),
        .lfsr_seed(lfsr_seed), .func_in(func_in), .uut_resp(resp1), .uut_in(in1),
        .uut_rst(rst1), .bist_running(run1), .bist_end(end1), .pass_fail(pf1), .signature_out(sig1));

    bist_engine #(.UUT_LAT(3), .GOLDEN(GOLD)) u_lat3 (
        .clock(clock), .reset(reset), .bist_start(bist_start), .bist_abort(bist_abort),
        .lfsr_seed(lfsr_seed), .func_in(func_in), .uut_resp(resp3), .uut_in(in3),
        .uut_rst(rst3), .bist_running(run3), .bist_end(end3), .pass_fail(pf3), .signature_out(sig3));

    function automatic logic [3:0] model_pat(input logic [3:0] seed, input int k);
        logic [3:0] s;
        s = (seed == 4'h0) ? 4'h1 : seed;
        for (int i = 0; i < k; i++) s = {s[2:0], s[3] ^ s[2]};
        return s;
    endfunction

    // Signature after the first n responses of the run.
    function automatic logic [7:0] model_sig(input logic [3:0] seed, input logic [3:0] mask,
                                             input bit stuck, input int n);
        logic [7:0] sig;
        logic [3:0] r;
        sig = 8'h00;
        for (int k = 0; k < n; k++) begin
            r = model_pat(seed, k) ^ mask;
            if (stuck) r[2] = 1'b0;
            sig = {sig[6:0], sig[7] ^ sig[5] ^ sig[4] ^ sig[3]} ^ {4'h0, r};
        end
        return sig;
    endfunction

    task automatic do_run(input logic [3:0] seed, input logic [3:0] mask, input bit stuck);
        int t0, t1, t3;
        logic p0, p1, p3;
        logic [7:0] e_sig, e_sig_f;
        t0 = -1; t1 = -1; t3 = -1;
        p0 = 1'b0; p1 = 1'b0; p3 = 1'b0;
        lfsr_seed = seed; xor_mask = mask; stuck2 = stuck;
        e_sig   = model_sig(seed, mask, 1'b0, P);
        e_sig_f = model_sig(seed, mask, stuck, P);
        bist_start = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            @(posedge clock); #1;
            if (n == 1) begin
                checks++;
                if ({rst1, run1, end1} !== 3'b110) begin
                    errors++; $display("FAIL init_outputs: got %b expected 110", {rst1, run1, end1});
                end
            end
            if (n >= 2 && n <= P + 1) begin
                checks++;
                if (in1 !== model_pat(seed, n - 2)) begin
                    errors++; $display("FAIL pattern[%0d]: got %h expected %h", n - 2, in1, model_pat(seed, n - 2));
                end
            end
            if (end0 && t0 < 0) begin t0 = n; p0 = pf0; end
            if (end1 && t1 < 0) begin t1 = n; p1 = pf1; end
            if (end3 && t3 < 0) begin t3 = n; p3 = pf3; end
        end
        checks++;
        if (t0 != 2 + P || t1 != 3 + P || t3 != 5 + P) begin
            errors++; $display("FAIL end_timing: got %0d/%0d/%0d expected %0d/%0d/%0d", t0, t1, t3, 2 + P, 3 + P, 5 + P);
        end
        checks++;
        if (sig0 !== e_sig || sig1 !== e_sig_f || sig3 !== e_sig) begin
            errors++; $display("FAIL signature: got %h/%h/%h expected %h/%h/%h", sig0, sig1, sig3, e_sig, e_sig_f, e_sig);
        end
        checks++;
        if ({p0, p1, p3} !== {e_sig == GOLD, e_sig_f == GOLD, e_sig == GOLD}) begin
            errors++; $display("FAIL pass_fail: got %b%b%b expected %b%b%b", p0, p1, p3, e_sig == GOLD, e_sig_f == GOLD, e_sig == GOLD);
        end
        checks++;
        if (end0 !== 1'b1) begin
            errors++; $display("FAIL done_hold: got %b expected 1", end0);
        end
        bist_start = 1'b0;
        @(posedge clock); #1;
        checks++;
        if ({end0, end1, end3, run1} !== 4'b0000 || sig1 !== e_sig_f || pf1 !== (e_sig_f == GOLD)) begin
            errors++; $display("FAIL back_to_idle: got end/run %b sig %h pf %b expected 0000 %h %b",
                               {end0, end1, end3, run1}, sig1, pf1, e_sig_f, e_sig_f == GOLD);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bist_start = 1'b0; bist_abort = 1'b0;
        lfsr_seed = 4'h0; xor_mask = 4'h0; stuck2 = 1'b0; func_in = 4'hA;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({rst0, rst1, rst3, run1, end1, pf1} !== 6'b111000 || sig0 !== 8'h00 || sig1 !== 8'h00
            || sig3 !== 8'h00 || in1 !== 4'hA) begin
            errors++; $display("FAIL reset_state: got %b sig %h in %h expected 111000 sig 00 in a",
                               {rst0, rst1, rst3, run1, end1, pf1}, sig1, in1);
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_golden_and_seed();
        do_run(4'h1, 4'h0, 1'b0);
        checks++;
        if (pf1 !== 1'b1 || sig1 !== 8'h01) begin
            errors++; $display("FAIL golden_pass: got pf %b sig %h expected 1 01", pf1, sig1);
        end
        do_run(4'h0, 4'h0, 1'b0);
        do_run(4'h1, 4'h0, 1'b1);
    endtask

    task automatic test_random_runs();
        for (int i = 0; i < 4; i++) begin
            do_run(4'($urandom_range(0, 15)), 4'($urandom), 1'b0);
        end
    endtask

    task automatic test_abort();
        logic [3:0] seed, mask;
        seed = 4'($urandom_range(1, 15)); mask = 4'($urandom);
        lfsr_seed = seed; xor_mask = mask; stuck2 = 1'b0; func_in = 4'($urandom);
        bist_start = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        bist_abort = 1'b1;
        @(posedge clock); #1;
        bist_abort = 1'b0;
        checks++;
        if ({run0, run1, run3, end0, end1, end3, pf0, pf1, pf3} !== 9'b0 || in1 !== func_in) begin
            errors++; $display("FAIL abort_state: got %b in %h expected 000000000 in %h",
                               {run0, run1, run3, end0, end1, end3, pf0, pf1, pf3}, in1, func_in);
        end
        checks++;
        if (sig0 !== model_sig(seed, mask, 1'b0, 4) || sig1 !== model_sig(seed, mask, 1'b0, 3)
            || sig3 !== model_sig(seed, mask, 1'b0, 1)) begin
            errors++; $display("FAIL abort_partial_sig: got %h/%h/%h expected %h/%h/%h", sig0, sig1, sig3,
                               model_sig(seed, mask, 1'b0, 4), model_sig(seed, mask, 1'b0, 3), model_sig(seed, mask, 1'b0, 1));
        end
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({run0, run1, run3, end1} !== 4'b0 || sig1 !== model_sig(seed, mask, 1'b0, 3)) begin
            errors++; $display("FAIL no_restart: got run/end %b sig %h expected 0000 %h",
                               {run0, run1, run3, end1}, sig1, model_sig(seed, mask, 1'b0, 3));
        end
        bist_start = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset_in_drain();
        logic [3:0] seed, mask;
        seed = 4'($urandom_range(0, 15)); mask = 4'($urandom);
        lfsr_seed = seed; xor_mask = mask; stuck2 = 1'b0;
        bist_start = 1'b1;
        repeat (P + 2) @(posedge clock);
        #1;
        checks++;
        if ({run1, end1} !== 2'b10) begin
            errors++; $display("FAIL drain_reached: got %b expected 10", {run1, end1});
        end
        reset = 1'b1; bist_start = 1'b0;
        @(posedge clock); #1;
        checks++;
        if ({rst1, run1, end1, pf1, end0, pf0} !== 6'b100000 || sig0 !== 8'h00 || sig1 !== 8'h00 || sig3 !== 8'h00) begin
            errors++; $display("FAIL reset_in_drain: got %b sig %h/%h/%h expected 100000 sig 00",
                               {rst1, run1, end1, pf1, end0, pf0}, sig0, sig1, sig3);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        do_run(seed, mask, 1'b0);
    endtask

    initial begin
        test_reset();
        test_golden_and_seed();
        test_random_runs();
        test_abort();
        test_reset_in_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
